// File: rtl/reg_file.sv
// Dual-read, single-write register file with registered, hold-on-idle read ports.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a colliding read.
module reg_file #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re_a,
  input  logic [DEPTH_LOG2-1:0] raddr_a,
  input  logic                  re_b,
  input  logic [DEPTH_LOG2-1:0] raddr_b,
  output logic [WIDTH-1:0]      rdata_a,
  output logic [WIDTH-1:0]      rdata_b
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [Depth];
  logic [WIDTH-1:0] rdata_a_d, rdata_b_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a_d = mem_q[raddr_a];
    rdata_b_d = mem_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (we && (waddr == raddr_a)) rdata_a_d = wdata;
    if (we && (waddr == raddr_b)) rdata_b_d = wdata;
`endif
  end

  // Outputs update only on an enabled read, otherwise they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= rdata_a_d;
      if (re_b) rdata_b <= rdata_b_d;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expected read data is queued when stimulus is
// driven and compared after the following rising edge.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, we, re_a, re_b;
  logic [2:0]  waddr, raddr_a, raddr_b;
  logic [15:0] wdata, rdata_a, rdata_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] model_mem [8];
  logic [15:0] exp_a = '0, exp_b = '0;
  logic [15:0] q_a [$];
  logic [15:0] q_b [$];

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re_a    (re_a),
    .raddr_a (raddr_a),
    .re_b    (re_b),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // One clock of stimulus; model predicts outputs, scoreboard compares them after the edge.
  task automatic step(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                      input logic ea, input logic [2:0] ra, input logic eb, input logic [2:0] rb);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd;
    re_a = ea; raddr_a = ra; re_b = eb; raddr_b = rb;
    if (r) begin
      exp_a = '0;
      exp_b = '0;
      for (int i = 0; i < 8; i++) model_mem[i] = '0;
    end else begin
      if (ea) exp_a = (Bypass && w && wa == ra) ? wd : model_mem[ra];
      if (eb) exp_b = (Bypass && w && wa == rb) ? wd : model_mem[rb];
      if (w) model_mem[wa] = wd;
    end
    q_a.push_back(exp_a);
    q_b.push_back(exp_b);
    @(posedge clk);
    #1;
    check("sb_rdata_a", rdata_a, q_a.pop_front());
    check("sb_rdata_b", rdata_b, q_b.pop_front());
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;

    // Reset overrides a concurrent write
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    wr(3'd3, 16'h1234);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd0);
    check("pre_reset_r3", rdata_a, 16'h1234);
    step(1'b1, 1'b1, 3'd3, 16'hFFFF, 1'b1, 3'd3, 1'b1, 3'd3);
    check("reset_rdata_a", rdata_a, 16'h0000);
    check("reset_rdata_b", rdata_b, 16'h0000);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd0);
    check("reset_r3_cleared", rdata_a, 16'h0000);

    // Write all, read ascending on A and descending on B
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1000 + i));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i));
      check("all_a", rdata_a, 16'(16'h1000 + i));
      check("all_b", rdata_b, 16'(16'h1007 - i));
    end

    // Hold on idle
    wr(3'd5, 16'hBEEF);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b0, 3'd0);
    check("hold_first", rdata_a, 16'hBEEF);
    wr(3'd5, 16'h0001);
    idle();
    check("hold_kept", rdata_a, 16'hBEEF);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b0, 3'd0);
    check("hold_reread", rdata_a, 16'h0001);

    // Read/write collision
    wr(3'd2, 16'h00AA);
    step(1'b0, 1'b1, 3'd2, 16'h0055, 1'b1, 3'd2, 1'b0, 3'd0);
    check("collision", rdata_a, Bypass ? 16'h0055 : 16'h00AA);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 3'd0);
    check("collision_after", rdata_a, 16'h0055);

    // Same-address dual read
    wr(3'd6, 16'hC0DE);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b1, 3'd6);
    check("dual_a", rdata_a, 16'hC0DE);
    check("dual_b", rdata_b, 16'hC0DE);

    // Random traffic, then reset pulsed during a write of 0x7777 to r1
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom),
           1'($urandom_range(1)), 3'($urandom_range(7)),
           1'($urandom_range(1)), 3'($urandom_range(7)));
    end
    step(1'b1, 1'b1, 3'd1, 16'h7777, 1'b1, 3'd1, 1'b1, 3'd4);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b0, 3'd0);
    check("midreset_r1", rdata_a, 16'h0000);
    wr(3'd1, 16'h0042);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd1);
    check("midreset_rewrite", rdata_b, 16'h0042);

    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom),
           1'($urandom_range(1)), 3'($urandom_range(7)),
           1'($urandom_range(1)), 3'($urandom_range(7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
